// File: rtl/pcie_c2h_dsc_gen_if.sv
// Request and XDMA descriptor-bypass bundle for pcie_c2h_dsc_gen.
// slave: generator view, master: producer/XDMA view.
interface pcie_c2h_dsc_gen_if;
  logic        req_valid;
  logic        req_ready;
  logic [27:0] req_len;
  logic [63:0] dsc_byp_dst_addr;
  logic [63:0] dsc_byp_src_addr;
  logic [27:0] dsc_byp_len;
  logic [15:0] dsc_byp_ctl;
  logic        dsc_byp_ready;
  logic        dsc_byp_load;

  modport slave (
    input  req_valid, req_len, dsc_byp_ready,
    output req_ready, dsc_byp_dst_addr, dsc_byp_src_addr,
    output dsc_byp_len, dsc_byp_ctl, dsc_byp_load
  );

  modport master (
    output req_valid, req_len, dsc_byp_ready,
    input  req_ready, dsc_byp_dst_addr, dsc_byp_src_addr,
    input  dsc_byp_len, dsc_byp_ctl, dsc_byp_load
  );
endinterface

// File: rtl/pcie_c2h_dsc_gen.sv
// XDMA C2H descriptor-bypass generator for a fixed-slot host ring.
// Optional statistics counters: define PCIE_C2H_DSC_STATS_EN.
module pcie_c2h_dsc_gen #(
  parameter logic [63:0] RING_BASE    = 64'h1_0000_0000,
  parameter int          RING_ENTRIES = 16,
  parameter logic [27:0] ENTRY_BYTES  = 28'h1000,
  parameter logic [15:0] DSC_CTL      = 16'h0000,
  localparam int         IW = $clog2(RING_ENTRIES)
) (
  input  logic          user_clk,
  input  logic          user_resetn,
  input  logic          user_lnk_up,
  pcie_c2h_dsc_gen_if.slave bus,
  input  logic          host_credit_valid,
  input  logic [8:0]    host_credit_cnt,
  output logic [8:0]    free_cnt,
  output logic [IW-1:0] prod_idx,
  output logic          err_clamp,
  output logic          err_credit_ovf,
  output logic [31:0]   stat_desc_cnt,
  output logic [31:0]   stat_stall_cyc
);

  typedef enum logic {IDLE, ISSUE} state_t;

  localparam logic [9:0] FULL = 10'(RING_ENTRIES);

  state_t        state_q;
  logic [63:0]   dst_q;
  logic [27:0]   len_q;
  logic [IW-1:0] prod_idx_q;
  logic [8:0]    free_q;
  logic          clamp_q;
  logic          ovf_q;

  logic          accept;
  logic          consume;
  logic          len_fix;
  logic [27:0]   len_d;
  logic [63:0]   dst_d;
  logic [9:0]    free_sum;
  logic [8:0]    free_d;
  logic          ovf_d;

  assign bus.req_ready = (state_q == IDLE) & user_lnk_up
                       & (free_q != 9'd0);
  assign accept  = bus.req_valid & bus.req_ready;
  assign bus.dsc_byp_load = (state_q == ISSUE)
                          & bus.dsc_byp_ready & user_lnk_up;
  assign consume = bus.dsc_byp_load;

  // Descriptor fields for the slot the next request lands in.
  always_comb begin
    len_fix = (bus.req_len == 28'd0) || (bus.req_len > ENTRY_BYTES);
    len_d   = len_fix ? ENTRY_BYTES : bus.req_len;
    dst_d   = RING_BASE + 64'(prod_idx_q) * 64'(ENTRY_BYTES);
  end

  // Credit bookkeeping; consume and host return apply together.
  always_comb begin
    free_sum = {1'b0, free_q} - {9'd0, consume}
             + (host_credit_valid ? {1'b0, host_credit_cnt} : 10'd0);
    ovf_d    = free_sum > FULL;
    free_d   = ovf_d ? FULL[8:0] : free_sum[8:0];
  end

  // Issue FSM with registered descriptor, index, credit and error state.
  always_ff @(posedge user_clk or negedge user_resetn) begin
    if (!user_resetn) begin
      state_q    <= IDLE;
      dst_q      <= RING_BASE;
      len_q      <= ENTRY_BYTES;
      prod_idx_q <= '0;
      free_q     <= FULL[8:0];
      clamp_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      free_q <= free_d;
      if (ovf_d) ovf_q <= 1'b1;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            dst_q   <= dst_d;
            len_q   <= len_d;
            state_q <= ISSUE;
            if (len_fix) clamp_q <= 1'b1;
          end
        end
        ISSUE: begin
          if (consume) begin
            state_q    <= IDLE;
            prod_idx_q <= prod_idx_q + IW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.dsc_byp_dst_addr = dst_q;
  assign bus.dsc_byp_src_addr = 64'd0;
  assign bus.dsc_byp_len      = len_q;
  assign bus.dsc_byp_ctl      = DSC_CTL;
  assign free_cnt             = free_q;
  assign prod_idx             = prod_idx_q;
  assign err_clamp            = clamp_q;
  assign err_credit_ovf       = ovf_q;

`ifdef PCIE_C2H_DSC_STATS_EN
  logic [31:0] desc_q;
  logic [31:0] stall_q;
  logic        stall;

  assign stall = ((state_q == ISSUE) & ~bus.dsc_byp_ready)
               | (bus.req_valid & (free_q == 9'd0));

  // Free-running wrap-around counters of issued descriptors and stalls.
  always_ff @(posedge user_clk or negedge user_resetn) begin
    if (!user_resetn) begin
      desc_q  <= 32'd0;
      stall_q <= 32'd0;
    end else begin
      if (consume) desc_q  <= desc_q + 32'd1;
      if (stall)   stall_q <= stall_q + 32'd1;
    end
  end

  assign stat_desc_cnt  = desc_q;
  assign stat_stall_cyc = stall_q;
`else
  assign stat_desc_cnt  = 32'd0;
  assign stat_stall_cyc = 32'd0;
`endif

endmodule

// File: tb/tb_pcie_c2h_dsc_gen.sv
// Scoreboard bench for pcie_c2h_dsc_gen: expected descriptors
// are queued at request time and popped whenever a load occurs.
module tb_pcie_c2h_dsc_gen;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lnk = 1'b0;
  logic        cr_v = 1'b0;
  logic [8:0]  cr_n = 9'd0;
  logic [8:0]  free_cnt;
  logic [3:0]  prod_idx;
  logic        err_clamp, err_ovf;
  logic [31:0] st_desc, st_stall;

  int total = 0;
  int passed = 0;
  int midx = 0;
  logic [91:0] expq[$];
  logic [91:0] last_exp;

  pcie_c2h_dsc_gen_if bus();

  pcie_c2h_dsc_gen dut (
    .user_clk         (clk),
    .user_resetn      (rst_n),
    .user_lnk_up      (lnk),
    .bus              (bus),
    .host_credit_valid(cr_v),
    .host_credit_cnt  (cr_n),
    .free_cnt         (free_cnt),
    .prod_idx         (prod_idx),
    .err_clamp        (err_clamp),
    .err_credit_ovf   (err_ovf),
    .stat_desc_cnt    (st_desc),
    .stat_stall_cyc   (st_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every load must match the oldest queued descriptor.
  always @(negedge clk) begin
    if (rst_n && bus.dsc_byp_load) begin
      chk("load_needs_ready", {63'd0, bus.dsc_byp_ready}, 64'd1);
      if (expq.size() == 0) begin
        chk("unexpected_load", 64'd1, 64'd0);
      end else begin
        logic [91:0] e;
        e = expq.pop_front();
        chk("dsc_dst", bus.dsc_byp_dst_addr, e[91:28]);
        chk("dsc_len", {36'd0, bus.dsc_byp_len}, {36'd0, e[27:0]});
        chk("dsc_src", bus.dsc_byp_src_addr, 64'd0);
        chk("dsc_ctl", {48'd0, bus.dsc_byp_ctl}, 64'd0);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accept edge.
  task automatic send(input logic [27:0] len, input logic [27:0] elen);
    int n;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      tick();
      n++;
    end
    if (!bus.req_ready) begin
      chk("req_ready_timeout", 64'd0, 64'd1);
    end else begin
      last_exp = {64'h1_0000_0000 + 64'(midx) * 64'h1000, elen};
      expq.push_back(last_exp);
      midx = (midx + 1) % 16;
      bus.req_valid = 1'b1;
      bus.req_len   = len;
      tick();
      bus.req_valid = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] s0;
    logic [8:0]  f0;
    int n;
    bus.req_valid     = 1'b0;
    bus.req_len       = 28'd0;
    bus.dsc_byp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_free", {55'd0, free_cnt}, 64'd16);
    chk("rst_prod", {60'd0, prod_idx}, 64'd0);
    chk("rst_dst", bus.dsc_byp_dst_addr, 64'h1_0000_0000);
    chk("rst_len", {36'd0, bus.dsc_byp_len}, 64'h1000);
    chk("rst_load", {63'd0, bus.dsc_byp_load}, 64'd0);
    chk("rst_ready", {63'd0, bus.req_ready}, 64'd0);
    chk("rst_errs", {62'd0, err_clamp, err_ovf}, 64'd0);
    chk("rst_stats", {st_desc, st_stall}, 64'd0);

    tick();
    lnk = 1'b1;
    bus.dsc_byp_ready = 1'b1;
    send(28'h200, 28'h200);
    @(negedge clk);
    chk("lat_load_n1", {63'd0, bus.dsc_byp_load}, 64'd1);
    tick();
    chk("one_load_only", {63'd0, bus.dsc_byp_load}, 64'd0);
    chk("prod_after1", {60'd0, prod_idx}, 64'd1);
    chk("free_after1", {55'd0, free_cnt}, 64'd15);
    chk("no_clamp_yet", {63'd0, err_clamp}, 64'd0);

    for (int i = 0; i < 15; i++) send(28'h80, 28'h80);
    tick();
    chk("full_free", {55'd0, free_cnt}, 64'd0);
    chk("full_prod_wrap", {60'd0, prod_idx}, 64'd0);
    chk("full_ready_low", {63'd0, bus.req_ready}, 64'd0);
    chk("last_dst_f000", last_exp[91:28], 64'h1_0000_F000);

    cr_v = 1'b1;
    cr_n = 9'd3;
    tick();
    cr_v = 1'b0;
    chk("credit3_free", {55'd0, free_cnt}, 64'd3);
    chk("credit3_ready", {63'd0, bus.req_ready}, 64'd1);
    chk("no_ovf_yet", {63'd0, err_ovf}, 64'd0);
    cr_v = 1'b1;
    cr_n = 9'd20;
    tick();
    cr_v = 1'b0;
    chk("credit20_sat", {55'd0, free_cnt}, 64'd16);
    chk("credit_ovf", {63'd0, err_ovf}, 64'd1);

    send(28'h2000, 28'h1000);
    send(28'h0, 28'h1000);
    tick();
    chk("err_clamp", {63'd0, err_clamp}, 64'd1);

    bus.dsc_byp_ready = 1'b0;
    send(28'h300, 28'h300);
    s0 = st_stall;
    for (int i = 0; i < 5; i++) begin
      lnk = (i == 1 || i == 2) ? 1'b0 : 1'b1;
      @(negedge clk);
      chk("stall_no_load", {63'd0, bus.dsc_byp_load}, 64'd0);
      chk("stall_dst", bus.dsc_byp_dst_addr, last_exp[91:28]);
      chk("stall_len", {36'd0, bus.dsc_byp_len}, 64'h300);
      tick();
    end
    lnk = 1'b1;
    bus.dsc_byp_ready = 1'b1;
    @(negedge clk);
    chk("stall_release", {63'd0, bus.dsc_byp_load}, 64'd1);
    tick();
`ifdef PCIE_C2H_DSC_STATS_EN
    chk("stall_cyc5", {32'd0, st_stall - s0}, 64'd5);
`else
    chk("stall_tied0", {32'd0, st_stall}, 64'd0);
`endif

    send(28'h40, 28'h40);
    f0 = free_cnt;
    cr_v = 1'b1;
    cr_n = 9'd1;
    tick();
    cr_v = 1'b0;
    chk("consume_and_ret", {55'd0, free_cnt}, {55'd0, f0});
    chk("prod_final", {60'd0, prod_idx}, 64'd4);

    n = 0;
    while (expq.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    chk("queue_drained", 64'(expq.size()), 64'd0);
`ifdef PCIE_C2H_DSC_STATS_EN
    chk("desc_cnt20", {32'd0, st_desc}, 64'd20);
`else
    chk("desc_tied0", {32'd0, st_desc}, 64'd0);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/pcie_c2h_dsc_gen.md
# pcie_c2h_dsc_gen

Generates XDMA C2H descriptor-bypass commands for a host-reserved ring of fixed-size receive slots. It sits between the C2H stream producer and the `pcie_c2h_bypass` descriptor-bypass port, in the `user_clk` (250 MHz, XDMA `axi_aclk`) domain.

It accepts one transfer request per packet and maps it to the next ring slot. It tracks free slots using credits returned by the host, and presents each descriptor on the bypass interface using XDMA's ready/load rule.

## Interface

Parameters:
- `RING_BASE`, default 64'h1_0000_0000: host physical base of the reserved ring.
- `RING_ENTRIES`, default 16: number of slots. Power of two, range 2..256.
- `ENTRY_BYTES`, default 28'h1000: slot size in bytes. Power of two.
- `DSC_CTL`, default 16'h0000: value driven on `dsc_byp_ctl`.

Ports:
- `user_clk`, in, 1: the single clock (XDMA `axi_aclk`).
- `user_resetn`, in, 1: reset, asynchronous, active-low.
- `user_lnk_up`, in, 1: PCIe link up.
- `req_valid`, in, 1: request for a transfer of one packet.
- `req_ready`, out, 1: request accepted when high together with `req_valid`.
- `req_len`, in, 28: packet length in bytes.
- `host_credit_valid`, in, 1: host returns consumed slots.
- `host_credit_cnt`, in, 9: number of slots returned.
- `dsc_byp_dst_addr`, out, 64: slot host address.
- `dsc_byp_src_addr`, out, 64: constant 0.
- `dsc_byp_len`, out, 28: descriptor length.
- `dsc_byp_ctl`, out, 16: equals `DSC_CTL`.
- `dsc_byp_ready`, in, 1: from XDMA.
- `dsc_byp_load`, out, 1: to XDMA.
- `free_cnt`, out, 9: free slots.
- `prod_idx`, out, log2(`RING_ENTRIES`): next slot index.
- `err_clamp`, out, 1: sticky flag.
- `err_credit_ovf`, out, 1: sticky flag.
- `stat_desc_cnt`, out, 32: see Configuration.
- `stat_stall_cyc`, out, 32: see Configuration.

## Operation

- FSM has two states, IDLE and ISSUE.
- Request handshake:
  - `req_ready` = IDLE & `user_lnk_up` & (`free_cnt` != 0).
  - Accept occurs when `req_valid` & `req_ready`.
- On accept, in the same edge:
  - Latch `dsc_byp_dst_addr` = `RING_BASE` + `prod_idx`·`ENTRY_BYTES`.
  - Latch `dsc_byp_len` = min(`req_len`, `ENTRY_BYTES`).
  - A `req_len` of 0 is replaced by `ENTRY_BYTES`.
  - Clamping (`req_len` > `ENTRY_BYTES`) or zero substitution sets `err_clamp`.
  - Go to ISSUE.
- In ISSUE, `dsc_byp_load` = `dsc_byp_ready` & `user_lnk_up`. This is combinational from registered state; load is never asserted without ready.
- Descriptor fields stay stable for the whole time the FSM is in ISSUE.
- A descriptor is consumed in the cycle where `dsc_byp_load` = 1. On that edge:
  - Go to IDLE.
  - `prod_idx` increments and wraps from `RING_ENTRIES`-1 to 0.
  - Consume one credit.
- Credit update: `free_cnt` ← `free_cnt` − consume + (`host_credit_valid` ? `host_credit_cnt` : 0).
  - Simultaneous consume and return are both applied in the same cycle.
  - A result above `RING_ENTRIES` saturates at `RING_ENTRIES` and sets `err_credit_ovf`.
- Link drop while in ISSUE:
  - The FSM stays in ISSUE with load suppressed.
  - The descriptor is issued after the link returns.
  - No state is lost.
- Sticky errors clear only on reset.

## Timing

- Reset values:
  - FSM in IDLE.
  - `free_cnt` = `RING_ENTRIES`.
  - `prod_idx` = 0.
  - `dsc_byp_dst_addr` = `RING_BASE`.
  - `dsc_byp_len` = `ENTRY_BYTES`.
  - `dsc_byp_load` = 0, `req_ready` = 0.
  - Errors and statistics = 0.
- Latency: request accepted at edge N; `dsc_byp_load` can be high in cycle N+1, earliest.
- Throughput: one descriptor per 2 cycles maximum.
- `req_ready` is low during the consume cycle; the next accept is at N+2.
- A credit returned at edge N makes `req_ready` high in cycle N+1 when the ring was full.

## Configuration

- Macro `PCIE_C2H_DSC_STATS_EN`.
- When defined:
  - `stat_desc_cnt` increments on each consumed descriptor.
  - `stat_stall_cyc` increments on each cycle where the FSM is in ISSUE & !`dsc_byp_ready`, or `req_valid` & `free_cnt` == 0.
  - Both counters wrap at 2^32 and reset to 0.
- When not defined: both outputs are tied to 0 and no counter logic is built.

## Test plan

- Reset, link up, `dsc_byp_ready` = 1, one request with `req_len` = 0x200 → a single-cycle load in cycle N+1 with dst 0x1_0000_0000 and len 0x200; then `prod_idx` = 1 and `free_cnt` = 15.
- 16 back-to-back requests with no credits → `req_ready` goes low after the 16th; `free_cnt` = 0; `prod_idx` wraps to 0; the last dst is 0x1_0000_F000.
- With the ring full, return `host_credit_cnt` = 3 → `free_cnt` = 3 and `req_ready` is high in the next cycle. Then return 20 → `free_cnt` saturates at 16 and `err_credit_ovf` = 1.
- `req_len` = 0x2000, then 0 → `dsc_byp_len` = 0x1000 both times and `err_clamp` = 1.
- Hold `dsc_byp_ready` = 0 for 5 cycles in ISSUE, and drop `user_lnk_up` for 2 of them → no load, fields stable. Load fires on the first cycle where both ready and link are high. With `PCIE_C2H_DSC_STATS_EN`, `stat_stall_cyc` = 5.
- Consume and a 1-credit return in the same cycle → `free_cnt` is unchanged.
